// File: rtl/custom_op_sequencer.sv
// custom_op_sequencer: multi-cycle BITREV / POPCOUNT / CLZ unit, BITS_PER_CYCLE bits per RUN cycle.
// Define CUSTOM_SEQ_EARLY_EXIT_EN to let CLZ and POPCOUNT leave RUN once their result is final.
module custom_op_sequencer #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      alucontrol,
  input  logic [XLEN-1:0] operand,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned B    = BITS_PER_CYCLE;
  localparam int unsigned NCYC = XLEN / B;
  localparam int unsigned CntW = (NCYC > 1) ? $clog2(NCYC) : 1;

  localparam logic [3:0] OpBitrev = 4'b1001;
  localparam logic [3:0] OpPopcnt = 4'b1010;
  localparam logic [3:0] OpClz    = 4'b1011;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e          state_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] sh_q, acc_q;
  logic [CntW-1:0] cnt_q;
  logic            found_q;

  logic            is_custom, accept, last, finish, found_d, lz_seen;
  logic [B-1:0]    chunk, chunk_rev;
  logic [XLEN-1:0] sh_d, acc_d, ones, lz;

  always_comb begin
    is_custom = (alucontrol == OpBitrev) || (alucontrol == OpPopcnt) || (alucontrol == OpClz);
    accept    = (state_q == StIdle) && start && is_custom;
    stall     = !reset && (accept || (state_q == StRun));

    chunk     = sh_q[XLEN-1 -: B];
    sh_d      = sh_q << B;
    chunk_rev = '0;
    ones      = '0;
    lz        = '0;
    lz_seen   = 1'b0;
    for (int j = 0; j < B; j++) begin
      chunk_rev[j] = chunk[B-1-j];
      ones         = ones + XLEN'(chunk[j]);
    end
    for (int j = B - 1; j >= 0; j--) begin
      if (chunk[j]) lz_seen = 1'b1;
      else if (!lz_seen) lz = lz + XLEN'(1);
    end

    acc_d   = acc_q;
    found_d = found_q;
    case (op_q)
      OpBitrev: acc_d = {chunk_rev, acc_q[XLEN-1:B]};
      OpPopcnt: acc_d = acc_q + ones;
      OpClz: begin
        // Once the first one is seen, later chunks no longer affect the count.
        if (!found_q) begin
          if (chunk == '0) begin
            acc_d = acc_q + XLEN'(B);
          end else begin
            acc_d   = acc_q + lz;
            found_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    last = (cnt_q == CntW'(NCYC - 1));
`ifdef CUSTOM_SEQ_EARLY_EXIT_EN
    finish = last || ((op_q == OpClz) && !found_q && found_d) ||
             ((op_q == OpPopcnt) && (sh_d == '0));
`else
    finish = last;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (accept) begin
            op_q    <= alucontrol;
            sh_q    <= operand;
            acc_q   <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            busy <= 1'b0;
          end
        end
        StRun: begin
          sh_q    <= sh_d;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + 1'b1;
          found_q <= found_d;
          if (finish) begin
            result  <= acc_d;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_custom_op_sequencer.sv
// Self-checking bench for custom_op_sequencer: cycle-level reference model plus directed cases.
// Honours CUSTOM_SEQ_EARLY_EXIT_EN for expected latencies.
module tb_custom_op_sequencer;

  localparam int unsigned XLEN = 32;
  localparam int unsigned B    = 4;
  localparam int unsigned NCYC = XLEN / B;
`ifdef CUSTOM_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  localparam logic [3:0] OP_BITREV = 4'b1001;
  localparam logic [3:0] OP_POP    = 4'b1010;
  localparam logic [3:0] OP_CLZ    = 4'b1011;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [3:0]      alucontrol;
  logic [XLEN-1:0] operand;
  logic            stall, busy, done;
  logic [XLEN-1:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  custom_op_sequencer #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alucontrol(alucontrol),
    .operand   (operand),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_custom(input logic [3:0] op);
    return (op == OP_BITREV) || (op == OP_POP) || (op == OP_CLZ);
  endfunction

  function automatic logic [XLEN-1:0] ref_result(input logic [3:0] op, input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = '0;
    if (op == OP_BITREV) begin
      for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
    end else if (op == OP_POP) begin
      r = XLEN'($countones(x));
    end else begin
      for (int i = XLEN - 1; i >= 0; i--) begin
        if (x[i]) break;
        r = r + 1;
      end
    end
    return r;
  endfunction

  // Number of RUN cycles the operation occupies.
  function automatic int ref_lat(input logic [3:0] op, input logic [XLEN-1:0] x);
    if (EE) begin
      if (op == OP_CLZ)
        for (int k = 1; k <= NCYC; k++) if ((x >> (XLEN - B * k)) != 0) return k;
      if (op == OP_POP)
        for (int k = 1; k <= NCYC; k++) if ((x << (B * k)) == 0) return k;
    end
    return NCYC;
  endfunction

  // Reference model: expectations for the current clock window, advanced at each negedge.
  int              m_run_left = 0;
  bit              m_done     = 1'b0;
  logic [XLEN-1:0] m_result   = '0;
  logic [XLEN-1:0] m_pending  = '0;
  bit              cmp_en     = 1'b0;

  always @(negedge clk) begin
    bit idle;
    if (cmp_en) begin
      idle = (m_run_left == 0) && !m_done;
      check("stall", 32'(stall),
            32'(!reset && ((idle && start && is_custom(alucontrol)) || (m_run_left > 0))));
      check("busy", 32'(busy), 32'((m_run_left > 0) || m_done));
      check("done", 32'(done), 32'(m_done));
      if (m_done) check("result", result, m_result);
      if (reset) begin
        m_run_left = 0;
        m_done     = 1'b0;
        m_result   = '0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_run_left > 0) begin
        m_run_left--;
        if (m_run_left == 0) begin
          m_done   = 1'b1;
          m_result = m_pending;
        end
      end else if (start && is_custom(alucontrol)) begin
        m_run_left = ref_lat(alucontrol, operand);
        m_pending  = ref_result(alucontrol, operand);
      end
    end
  end

  // Called just after a posedge with the DUT idle; returns just after a posedge, DUT idle.
  task automatic run_op(input string name, input logic [3:0] op, input logic [XLEN-1:0] x,
                        input logic [XLEN-1:0] exp_res, input int exp_lat, input int chg_at);
    int k;
    bit seen;
    seen       = 1'b0;
    start      = 1'b1;
    alucontrol = op;
    operand    = x;
    for (k = 0; k <= NCYC + 4; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (k + 1 == chg_at) operand = $urandom;
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(k), 32'(exp_lat));
    check({name, " result"}, result, exp_res);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [3:0]      op;
    logic [XLEN-1:0] x;
    reset      = 1'b1;
    start      = 1'b0;
    alucontrol = '0;
    operand    = '0;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", result, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_op("bitrev1", OP_BITREV, 32'h0000_0001, 32'h8000_0000, 9, 0);
    run_op("pop_mix", OP_POP, 32'hF0F0_00FF, 32'd16, 9, 0);
    run_op("pop_ones", OP_POP, 32'hFFFF_FFFF, 32'd32, 9, 0);
    run_op("pop_zero", OP_POP, 32'h0, 32'd0, EE ? 2 : 9, 0);
    run_op("clz_bit16", OP_CLZ, 32'h0001_0000, 32'd15, EE ? 5 : 9, 0);
    run_op("clz_zero", OP_CLZ, 32'h0, 32'd32, 9, 0);
    run_op("clz_msb", OP_CLZ, 32'h8000_0000, 32'd0, EE ? 2 : 9, 0);

    // Non-custom code must be ignored entirely.
    start      = 1'b1;
    alucontrol = 4'b0000;
    operand    = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("noncustom stall", 32'(stall), 32'd0);
      check("noncustom busy", 32'(busy), 32'd0);
      check("noncustom done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    // Reset during window T+4 of a POPCOUNT aborts it.
    start      = 1'b1;
    alucontrol = OP_POP;
    operand    = 32'h1234_5678;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    @(posedge clk);
    #1;
    run_op("clz_after_reset", OP_CLZ, 32'h0000_FFFF, 32'd16, EE ? 6 : 9, 0);

    // Operand changes at T+3 must not disturb the latched value.
    run_op("bitrev_chg", OP_BITREV, 32'h1234_5678, 32'h1E6A_2C48, 9, 3);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        op = 4'($urandom_range(0, 15));
        if (is_custom(op)) op = 4'b0000;
        start      = 1'b1;
        alucontrol = op;
        operand    = $urandom;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
        start = 1'b0;
      end else begin
        case ($urandom_range(0, 2))
          0:       op = OP_BITREV;
          1:       op = OP_POP;
          default: op = OP_CLZ;
        endcase
        case ($urandom_range(0, 4))
          0:       x = '0;
          1:       x = '1;
          2:       x = 32'd1 << $urandom_range(0, 31);
          3:       x = 32'($urandom) >> $urandom_range(0, 31);
          default: x = $urandom;
        endcase
        run_op("random", op, x, ref_result(op, x), ref_lat(op, x) + 1,
               int'($urandom_range(0, 6)));
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
